series_job_arbiter: RTL and testbench
=====================================

// Module: series_job_arbiter
// PURPOSE
//  Round-robin scheduler sharing one series-evaluation datapath (n/x operand loader, t*x / r+t iterator) among NREQ requesters.
//  Latches the winning job's operands and replays the datapath start protocol: start pulse, n, x low half, x high half, start release.
//  Waits for the datapath to return to ready, then returns the result to the winner with a one-cycle ack.
// PARAMETERS
//  NREQ  4    number of requesters (2..8)
//  DW    8    datapath operand bus width; x is 2*DW bits, n is DW bits
//  RW    16   result width
//  TMO   255  watchdog limit in S_RUN cycles (used only with SERIES_WATCHDOG_EN)
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          reset, asynchronous, active-high
//  req         in   NREQ       per-requester job request; level, held until ack
//  req_n       in   NREQ*DW    per-requester n, slice i = [i*DW +: DW]
//  req_x       in   NREQ*2*DW  per-requester x, slice i = [i*2*DW +: 2*DW]
//  ack         out  NREQ       one-hot, one-cycle completion pulse
//  rsp_result  out  RW         result; valid only while ack != 0
//  rsp_err     out  1          job aborted by watchdog; valid with ack
//  busy        out  1          job in flight (state != S_IDLE)
//  dp_start    out  1          datapath start
//  dp_bus      out  DW         datapath operand bus
//  dp_abort    out  1          one-cycle datapath abort/soft reset
//  dp_ready    in   1          datapath idle/ready
//  dp_result   in   RW         datapath accumulator r
// BEHAVIOUR
//  - Reset: state=S_IDLE, rr_ptr=0, ack=0, rsp_result=0, rsp_err=0, busy=0, dp_start=0, dp_bus=0, dp_abort=0. Reset mid-job abandons the job; no ack is issued.
//  - All outputs are registered or decoded from state only; dp_bus=0 outside the S_LD_* states.
//  - S_IDLE: if |req && dp_ready, grant the first set req at or after rr_ptr (wrapping modulo NREQ).
//    Latch gid, n_q and x_q in the same cycle, then go to S_START. Otherwise stay in S_IDLE.
//  - Sequence, one cycle per state:
//    S_START  (dp_start=1, bus=0) -> S_LD_N  (dp_start=1, bus=n_q) -> S_LD_XL (dp_start=1, bus=x_q[DW-1:0])
//    -> S_LD_XH (dp_start=1, bus=x_q[2DW-1:DW]) -> S_REL (dp_start=0) -> S_RUN.
//  - S_RUN: wait for dp_ready==1, then capture dp_result and go to S_DONE.
//    dp_ready is not sampled before S_RUN, because the datapath leaves ready from the S_LD_N cycle onward.
//  - S_DONE: ack[gid]=1, rsp_result=captured value, rr_ptr<=gid+1 (wraps NREQ-1 -> 0), then S_IDLE.
//  - Grant-to-ack latency = 6 + run cycles.
//  - Requester handshake: req[i] must be low by the clock edge that ends its ack cycle. Operand changes after grant are ignored.
//  - A req that drops before grant is not served; a req that drops after grant is still completed and acked.
//  - Simultaneous requests: the lowest index at or after rr_ptr wins. A single persistent requester is served back-to-back with a 1-cycle S_IDLE gap.
//  - New requests arriving during a job are not seen until S_IDLE.
// CONFIGURATION
//  SERIES_WATCHDOG_EN defined:
//   - A counter of $clog2(TMO+1) bits clears on S_RUN entry and increments each S_RUN cycle.
//   - When it reaches TMO with dp_ready still 0: pulse dp_abort=1 for one cycle, go to S_DONE with rsp_result=0 and rsp_err=1.
//   - rr_ptr advances normally.
//  SERIES_WATCHDOG_EN undefined: S_RUN waits indefinitely; dp_abort and rsp_err are tied to 0; no counter is instantiated.
// STRUCTURE
//  - Package series_pkg: state localparams S_IDLE..S_DONE (3 bits), default DW/RW, and a clog2 function.
//  - Sub-module rr_pick: combinational (req, rr_ptr) -> one-hot grant plus encoded gid, valid.
//  - FSM, operand latch, rr_ptr register and watchdog stay in this module.
// TESTING
//  1. Single job: req[2]=1, n=5, x=16'h0302.
//     -> dp_bus sequence 00, 05, 02, 03 with dp_start high for exactly 4 cycles.
//     -> with the model returning 16'h00F0, ack=4'b0100 and rsp_result=16'h00F0.
//  2. Contention: req=4'b1111 held from reset.
//     -> ack order 0,1,2,3,0 with a 1-cycle S_IDLE gap between jobs.
//  3. Wrap: rr_ptr=3 after serving 2; req=4'b1001 -> 3 served first, then 0.
//  4. Busy datapath: dp_ready=0 in S_IDLE with req[1]=1 -> no dp_start until dp_ready=1.
//  5. Reset mid-job: rst pulsed during S_RUN.
//     -> all outputs 0 next cycle, no ack, next grant starts from requester 0.
//  6. With SERIES_WATCHDOG_EN and TMO=10: dp_ready stuck at 0.
//     -> dp_abort pulse after 10 S_RUN cycles, ack with rsp_err=1 and rsp_result=0.

Source files
------------

// File: rtl/series_pkg.sv
// Shared definitions for the series-evaluation job arbiter.
//   state_t : FSM state encoding (3 bits), S_IDLE..S_DONE
//   DEF_DW  : default datapath operand bus width
//   DEF_RW  : default result width
//   clog2   : elaboration-time ceiling log2
package series_pkg;

    localparam int unsigned DEF_DW = 8;
    localparam int unsigned DEF_RW = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_LD_N  = 3'd2,
        S_LD_XL = 3'd3,
        S_LD_XH = 3'd4,
        S_REL   = 3'd5,
        S_RUN   = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Ceiling log2, used to size counters and pointers.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/series_job_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   req    in   NREQ   pending requests
//   rr_ptr in   PW     first index to consider
//   grant  out  NREQ   one-hot winner
//   gid    out  PW     encoded winner
//   valid  out  1      any request pending
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   gid,
    output logic            valid
);

    // Scan from rr_ptr upward with wrap; first set request wins.
    always_comb begin
        int unsigned sum;
        logic [PW-1:0] idx;
        grant = '0;
        gid   = '0;
        valid = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = 32'(rr_ptr) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = PW'(sum);
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                gid        = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/series_job_arbiter.sv
// series_job_arbiter: round-robin sharing of one series-evaluation datapath.
// Replays the datapath load protocol for the winning job, waits for the
// datapath to finish, and returns the result with a one-cycle ack.
// Optional feature macro: SERIES_WATCHDOG_EN (S_RUN timeout with dp_abort).
// Ports:
//   clk, rst                     clock, async active-high reset
//   req/req_n/req_x              per-requester job request and operands
//   ack/rsp_result/rsp_err       one-hot completion pulse and response
//   busy                         job in flight
//   dp_start/dp_bus/dp_abort     datapath control and operand bus
//   dp_ready/dp_result           datapath status and accumulator
module series_job_arbiter
    import series_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned RW   = DEF_RW,
    parameter int unsigned TMO  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_n,
    input  logic [NREQ*2*DW-1:0] req_x,
    output logic [NREQ-1:0]      ack,
    output logic [RW-1:0]        rsp_result,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 dp_start,
    output logic [DW-1:0]        dp_bus,
    output logic                 dp_abort,
    input  logic                 dp_ready,
    input  logic [RW-1:0]        dp_result
);

    localparam int unsigned PW = clog2(NREQ);

    state_t            state, state_n;
    logic [PW-1:0]     rr_ptr, gid_q, pick_gid;
    logic [NREQ-1:0]   gnt_q, pick_grant;
    logic              pick_valid;
    logic [DW-1:0]     n_q;
    logic [2*DW-1:0]   x_q;
    logic              take, timeout, wd_hit;
    logic [NREQ-1:0]   ack_n;
    logic [RW-1:0]     result_n;
    logic              err_n, abort_n, busy_n, start_n;
    logic [DW-1:0]     bus_n;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .gid    (pick_gid),
        .valid  (pick_valid)
    );

`ifdef SERIES_WATCHDOG_EN
    localparam int unsigned WW = clog2(TMO + 1);
    logic [WW-1:0] wd_cnt;

    // Counts S_RUN cycles; held at zero everywhere else so it restarts on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state != S_RUN) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WW'(1);
        end
    end

    // True in the TMO-th S_RUN cycle.
    assign wd_hit = (state == S_RUN) && (wd_cnt == WW'(TMO - 1));
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(TMO);
    assign wd_hit     = 1'b0;
`endif

    // Next state and next registered output values.
    always_comb begin
        state_n  = state;
        take     = 1'b0;
        timeout  = 1'b0;
        ack_n    = '0;
        result_n = '0;
        err_n    = 1'b0;
        abort_n  = 1'b0;
        bus_n    = '0;
        case (state)
            S_IDLE: begin
                if (pick_valid && dp_ready) begin
                    take    = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: state_n = S_LD_N;
            S_LD_N:  state_n = S_LD_XL;
            S_LD_XL: state_n = S_LD_XH;
            S_LD_XH: state_n = S_REL;
            S_REL:   state_n = S_RUN;
            S_RUN: begin
                if (dp_ready) begin
                    state_n = S_DONE;
                end else if (wd_hit) begin
                    state_n = S_DONE;
                    timeout = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (state == S_RUN && state_n == S_DONE) begin
            ack_n    = gnt_q;
            result_n = timeout ? '0 : dp_result;
            err_n    = timeout;
            abort_n  = timeout;
        end

        busy_n  = (state_n != S_IDLE);
        start_n = state_n inside {S_START, S_LD_N, S_LD_XL, S_LD_XH};
        case (state_n)
            S_LD_N:  bus_n = n_q;
            S_LD_XL: bus_n = x_q[DW-1:0];
            S_LD_XH: bus_n = x_q[2*DW-1:DW];
            default: bus_n = '0;
        endcase
    end

    // State, operand latch, round-robin pointer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            gid_q      <= '0;
            gnt_q      <= '0;
            n_q        <= '0;
            x_q        <= '0;
            ack        <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            dp_start   <= 1'b0;
            dp_bus     <= '0;
            dp_abort   <= 1'b0;
        end else begin
            state      <= state_n;
            ack        <= ack_n;
            rsp_result <= result_n;
            rsp_err    <= err_n;
            busy       <= busy_n;
            dp_start   <= start_n;
            dp_bus     <= bus_n;
            dp_abort   <= abort_n;
            if (take) begin
                gid_q <= pick_gid;
                gnt_q <= pick_grant;
                n_q   <= req_n[pick_gid*DW +: DW];
                x_q   <= req_x[pick_gid*2*DW +: 2*DW];
            end
            if (state == S_DONE) begin
                rr_ptr <= (gid_q == PW'(NREQ - 1)) ? '0 : gid_q + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_series_job_arbiter.sv
// Scoreboard bench for series_job_arbiter with a behavioural datapath model.
module tb_series_job_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned DW     = 8;
    localparam int unsigned RW     = 16;
    localparam int unsigned TB_TMO = 10;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_n;
    logic [NREQ*2*DW-1:0] req_x;
    logic [NREQ-1:0]      ack;
    logic [RW-1:0]        rsp_result;
    logic                 rsp_err;
    logic                 busy;
    logic                 dp_start;
    logic [DW-1:0]        dp_bus;
    logic                 dp_abort;
    logic                 dp_ready;
    logic [RW-1:0]        dp_result;

    series_job_arbiter #(.NREQ(NREQ), .DW(DW), .RW(RW), .TMO(TB_TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_n      (req_n),
        .req_x      (req_x),
        .ack        (ack),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .dp_start   (dp_start),
        .dp_bus     (dp_bus),
        .dp_abort   (dp_abort),
        .dp_ready   (dp_ready),
        .dp_result  (dp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] ack;
        logic [RW-1:0]   res;
        logic            err;
    } exp_t;

    exp_t sbq[$];
    int   ack_cyc[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   persist = 0;

    // Datapath model controls
    logic [DW-1:0] cap [4];
    int   start_hi = 0;
    int   m_cnt    = 0;
    int   m_run    = 0;
    bit   m_counting = 0;
    bit   m_ready  = 1;
    int   run_len  = 0;
    bit   stuck    = 0;
    bit   hold_busy = 0;
    bit   force_en = 0;
    logic [RW-1:0] force_val = '0;

    assign dp_ready = m_ready && !hold_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] a, input logic [RW-1:0] r, input logic e);
        exp_t x;
        x.ack = a;
        x.res = r;
        x.err = e;
        sbq.push_back(x);
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, sbq.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Datapath model: captures the start sequence, drops ready, returns a result.
    initial begin
        dp_result = '0;
        forever begin
            @(negedge clk);
            if (rst || dp_abort) begin
                m_cnt = 0;
                m_counting = 0;
                m_ready = 1;
            end else if (dp_start) begin
                if (m_cnt < 4) cap[m_cnt] = dp_bus;
                m_cnt++;
                start_hi++;
                m_ready = 0;
            end else if (m_cnt >= 4 && !m_counting) begin
                m_counting = 1;
                m_run = run_len;
            end
            if (m_counting && !stuck && !rst) begin
                if (m_run == 0) begin
                    m_ready = 1;
                    dp_result = force_en ? force_val : {cap[3] ^ cap[1], cap[2] ^ cap[1]};
                    m_counting = 0;
                    m_cnt = 0;
                end else begin
                    m_run--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every ack and releases the acked requester.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ack != '0) begin
                ack_cyc.push_back(cyc);
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_ack: ack=%b with empty scoreboard", ack);
                end else begin
                    e = sbq.pop_front();
                    check("ack", 32'(ack), 32'(e.ack));
                    check("rsp_result", 32'(rsp_result), 32'(e.res));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("dp_abort_at_ack", 32'(dp_abort), 32'(e.err));
                end
                if (!persist) req = req & ~ack;
                else if (sbq.size() == 0) req = '0;
            end else if (!rst && dp_abort) begin
                n_vec++;
                n_bad++;
                $display("FAIL stray_abort: dp_abort=1 without ack");
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int s0;
        int seen_start;
        int seen_busy;
        rst   = 1'b1;
        req   = '0;
        req_n = {8'h7F, 8'h05, 8'h22, 8'h11};
        req_x = {16'hFF00, 16'h0302, 16'h1234, 16'hA55A};
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_outputs", {ack, rsp_result, rsp_err, busy, dp_start, dp_bus, dp_abort}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);

        // 1. Single job on requester 2, forced model result
        force_en = 1;
        force_val = 16'h00F0;
        run_len = 2;
        s0 = start_hi;
        push(4'b0100, 16'h00F0, 1'b0);
        req[2] = 1'b1;
        drain("drain_single", 60);
        check("bus_seq0", 32'(cap[0]), 32'h00);
        check("bus_seq1", 32'(cap[1]), 32'h05);
        check("bus_seq2", 32'(cap[2]), 32'h02);
        check("bus_seq3", 32'(cap[3]), 32'h03);
        check("start_cycles", start_hi - s0, 4);
        force_en = 0;
        repeat (2) @(negedge clk);

        // 3. Wrap: pointer now at 3, so 3 is served before 0
        run_len = 3;
        push(4'b1000, 16'h807F, 1'b0);
        push(4'b0001, 16'hB44B, 1'b0);
        req = 4'b1001;
        drain("drain_wrap", 120);
        repeat (2) @(negedge clk);

        // 4. Busy datapath holds off the grant; operand change after grant ignored
        hold_busy = 1;
        run_len = 1;
        push(4'b0010, 16'h3016, 1'b0);
        req[1] = 1'b1;
        seen_start = 0;
        seen_busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dp_start) seen_start++;
            if (busy) seen_busy++;
        end
        check("busy_no_start", seen_start, 0);
        check("busy_no_grant", seen_busy, 0);
        hold_busy = 0;
        k = 0;
        while (!busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("grant_after_ready", 32'(busy), 32'h1);
        req_n[1*DW +: DW] = 8'hEE;
        drain("drain_busy", 60);
        req_n[1*DW +: DW] = 8'h22;
        repeat (2) @(negedge clk);

        // 5. Reset during S_RUN abandons the job
        run_len = 20;
        req[0] = 1'b1;
        k = 0;
        while (!busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (8) @(negedge clk);
        check("in_run_before_reset", 32'(busy), 32'h1);
        rst = 1'b1;
        req = '0;
        #1;
        check("rst_mid_outputs", {ack, rsp_result, rsp_err, busy, dp_start, dp_bus, dp_abort}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 2. Contention from reset pointer: 0,1,2,3,0 with one idle cycle between jobs
        run_len = 0;
        ack_cyc.delete();
        persist = 1;
        push(4'b0001, 16'hB44B, 1'b0);
        push(4'b0010, 16'h3016, 1'b0);
        push(4'b0100, 16'h0607, 1'b0);
        push(4'b1000, 16'h807F, 1'b0);
        push(4'b0001, 16'hB44B, 1'b0);
        req = 4'b1111;
        drain("drain_contention", 120);
        persist = 0;
        check("contention_acks", ack_cyc.size(), 5);
        for (int i = 1; i < 5; i++) begin
            if (i < ack_cyc.size()) check("ack_interval", ack_cyc[i] - ack_cyc[i-1], 8);
        end
        repeat (2) @(negedge clk);

`ifdef SERIES_WATCHDOG_EN
        // 6. Stuck datapath aborted by the watchdog
        stuck = 1;
        push(4'b1000, 16'h0000, 1'b1);
        req[3] = 1'b1;
        drain("drain_watchdog", 80);
        stuck = 0;
        repeat (3) @(negedge clk);
        check("post_abort_idle", 32'(busy), 32'h0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
